// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: one shared period counter, per-channel comparators, shadow/active duty registers.
// Define PWM_CENTER_ALIGNED_EN to add the center_mode input (up/down counting).
module pwm_multi_ch #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16,
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [CNT_W-1:0]  period,
   input  logic              duty_wr_en,
   input  logic [CH_W-1:0]   duty_wr_ch,
   input  logic [CNT_W-1:0]  duty_wr_data,
   input  logic              update_req,
`ifdef PWM_CENTER_ALIGNED_EN
   input  logic              center_mode,
`endif
   output logic [NUM_CH-1:0] pwm_out,
   output logic [CNT_W-1:0]  cnt,
   output logic              period_done,
   output logic              update_pending
);

   localparam logic [31:0] NUM_CH_U = NUM_CH;

   logic [CNT_W-1:0] shadow   [NUM_CH];
   logic [CNT_W-1:0] duty_act [NUM_CH];
   logic [CNT_W-1:0] per_act;
   logic [CNT_W-1:0] cnt_next;
   logic [CNT_W-1:0] next_per;
   logic [CNT_W-1:0] restart;
   logic             wrap;
   logic             commit;
   logic             wr_hit;

`ifdef PWM_CENTER_ALIGNED_EN
   logic dir;
   logic center_act;
`endif

   assign wr_hit = duty_wr_en && ({{(32-CH_W){1'b0}}, duty_wr_ch} < NUM_CH_U);

   always_comb begin
      wrap     = (cnt == per_act);
      cnt_next = cnt + CNT_W'(1);
`ifdef PWM_CENTER_ALIGNED_EN
      if (center_act && (per_act != '0)) begin
         wrap     = dir && (cnt == '0);
         cnt_next = (dir || (cnt == per_act)) ? (cnt - CNT_W'(1)) : (cnt + CNT_W'(1));
      end
`endif
      commit   = (update_pending | update_req) & (~en | wrap);
      next_per = commit ? period : per_act;
      restart  = '0;
`ifdef PWM_CENTER_ALIGNED_EN
      // A center-aligned period restarts at 1 so that 0 is visited once per period.
      if ((commit ? center_mode : center_act) && (next_per != '0))
         restart = CNT_W'(1);
`endif
      if (wrap)
         cnt_next = restart;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt            <= '0;
         pwm_out        <= '0;
         period_done    <= 1'b0;
         update_pending <= 1'b0;
         per_act        <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            shadow[i]   <= '0;
            duty_act[i] <= '0;
         end
      end else begin
         if (en) begin
            cnt         <= cnt_next;
            period_done <= wrap;
            for (int i = 0; i < NUM_CH; i++)
               pwm_out[i] <= (cnt < duty_act[i]);
         end else begin
            cnt         <= '0;
            period_done <= 1'b0;
            pwm_out     <= '0;
         end

         // Commit reads the pre-write shadow; a same-cycle write lands afterwards.
         if (commit) begin
            for (int i = 0; i < NUM_CH; i++)
               duty_act[i] <= shadow[i];
            per_act        <= period;
            update_pending <= 1'b0;
         end else if (update_req) begin
            update_pending <= 1'b1;
         end

         if (wr_hit)
            shadow[duty_wr_ch] <= duty_wr_data;
      end
   end

`ifdef PWM_CENTER_ALIGNED_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dir        <= 1'b0;
         center_act <= 1'b0;
      end else begin
         if (!en || commit)
            center_act <= center_mode;
         if (!en || wrap)
            dir <= 1'b0;
         else if (center_act && (per_act != '0) && !dir && (cnt == per_act))
            dir <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Bench for pwm_multi_ch: directed scenarios plus random traffic against a period/modulo model.
module tb_pwm_multi_ch;
   localparam int NCH = 3;
   localparam int W   = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic           en;
   logic [W-1:0]   period;
   logic           duty_wr_en;
   logic [1:0]     duty_wr_ch;
   logic [W-1:0]   duty_wr_data;
   logic           update_req;
   logic [NCH-1:0] pwm_out;
   logic [W-1:0]   cnt;
   logic           period_done;
   logic           update_pending;

   int n_cmp = 0;
   int n_bad = 0;
   logic chk_on = 1'b0;

   // model state
   logic [31:0]    m_cnt, m_per;
   logic [31:0]    m_duty   [NCH];
   logic [31:0]    m_shadow [NCH];
   logic           m_pend, e_done;
   logic [NCH-1:0] e_pwm;

   pwm_multi_ch #(.NUM_CH(NCH), .CNT_W(W)) dut (
      .clk(clk), .rst(rst), .en(en), .period(period),
      .duty_wr_en(duty_wr_en), .duty_wr_ch(duty_wr_ch), .duty_wr_data(duty_wr_data),
      .update_req(update_req), .pwm_out(pwm_out), .cnt(cnt),
      .period_done(period_done), .update_pending(update_pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Counter position is (previous + 1) modulo the period length; outputs follow one clock later.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cnt  <= 0;
         m_per  <= 0;
         m_pend <= 1'b0;
         e_done <= 1'b0;
         e_pwm  <= '0;
         for (int i = 0; i < NCH; i++) begin
            m_duty[i]   <= 0;
            m_shadow[i] <= 0;
         end
      end else begin
         for (int i = 0; i < NCH; i++)
            e_pwm[i] <= en && (m_cnt < m_duty[i]);
         e_done <= en && (m_cnt == m_per);
         m_cnt  <= en ? (m_cnt + 1) % (m_per + 1) : 0;
         if ((m_pend || update_req) && (!en || (m_cnt == m_per))) begin
            m_duty <= m_shadow;
            m_per  <= 32'(period);
            m_pend <= 1'b0;
         end else if (update_req) begin
            m_pend <= 1'b1;
         end
         if (duty_wr_en && (int'(duty_wr_ch) < NCH))
            m_shadow[duty_wr_ch] <= 32'(duty_wr_data);
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("cnt", 32'(cnt), m_cnt);
         check("pwm_out", 32'(pwm_out), 32'(e_pwm));
         check("period_done", 32'(period_done), 32'(e_done));
         check("update_pending", 32'(update_pending), 32'(m_pend));
      end
   end

   task automatic step();
      @(negedge clk);
      duty_wr_en = 1'b0;
      update_req = 1'b0;
   endtask

   task automatic write_duty(input int ch, input int val);
      duty_wr_en   = 1'b1;
      duty_wr_ch   = 2'(ch);
      duty_wr_data = W'(val);
      step();
   endtask

   task automatic wait_cnt(input int v);
      int k = 0;
      while ((cnt != W'(v)) && (k < 300)) begin
         @(negedge clk);
         k++;
      end
      check("wait_cnt_bound", 32'(k < 300), 32'd1);
   endtask

   task automatic window(input int n, output int hi0, output int hi1, output int hi2, output int dn);
      hi0 = 0; hi1 = 0; hi2 = 0; dn = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         hi0 += int'(pwm_out[0]);
         hi1 += int'(pwm_out[1]);
         hi2 += int'(pwm_out[2]);
         dn  += int'(period_done);
      end
   endtask

   initial begin
      int h0, h1, h2, dn;
      rst = 1'b1; en = 1'b0; period = '0; duty_wr_en = 1'b0;
      duty_wr_ch = '0; duty_wr_data = '0; update_req = 1'b0;
      repeat (2) @(negedge clk);
      chk_on = 1'b1;
      check("reset_cnt", 32'(cnt), 32'd0);
      check("reset_pwm", 32'(pwm_out), 32'd0);
      rst = 1'b0;

      // duty 3 / 0 / 20 with period 9
      en = 1'b1; period = W'(9);
      write_duty(0, 3);
      write_duty(1, 0);
      write_duty(2, 20);
      update_req = 1'b1; step();
      repeat (12) step();
      window(10, h0, h1, h2, dn);
      check("ch0_high_of_10", 32'(h0), 32'd3);
      check("ch1_const_low", 32'(h1), 32'd0);
      check("ch2_const_high", 32'(h2), 32'd10);
      check("done_per_10", 32'(dn), 32'd1);

      // mid-period duty change waits for the wrap
      wait_cnt(4);
      duty_wr_en = 1'b1; duty_wr_ch = 2'd0; duty_wr_data = W'(7); update_req = 1'b1;
      step();
      check("pending_mid_period", 32'(update_pending), 32'd1);
      repeat (12) step();
      window(10, h0, h1, h2, dn);
      check("ch0_high_7_of_10", 32'(h0), 32'd7);

      // period change ignored until committed
      period = W'(4);
      repeat (15) step();
      window(10, h0, h1, h2, dn);
      check("period_unchanged", 32'(dn), 32'd1);
      update_req = 1'b1; step();
      repeat (12) step();
      window(10, h0, h1, h2, dn);
      check("period_5_done", 32'(dn), 32'd2);

      // enable drop and restart
      wait_cnt(2);
      en = 1'b0; step();
      check("en_off_cnt", 32'(cnt), 32'd0);
      check("en_off_pwm", 32'(pwm_out), 32'd0);
      en = 1'b1; step();
      check("en_restart_cnt", 32'(cnt), 32'd1);

      // asynchronous reset mid-period
      period = W'(9); update_req = 1'b1; step();
      repeat (12) step();
      wait_cnt(6);
      #2 rst = 1'b1;
      #1;
      check("async_rst_cnt", 32'(cnt), 32'd0);
      check("async_rst_pwm", 32'(pwm_out), 32'd0);
      check("async_rst_done", 32'(period_done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      period = W'(4); update_req = 1'b1; step();
      repeat (5) step();
      window(10, h0, h1, h2, dn);
      check("shadow_cleared", 32'(h0 + h1 + h2), 32'd0);
      check("post_rst_done", 32'(dn), 32'd2);

      // random traffic
      for (int i = 0; i < 2000; i++) begin
         en           = ($urandom_range(0, 19) != 0);
         duty_wr_en   = ($urandom_range(0, 2) == 0);
         duty_wr_ch   = 2'($urandom_range(0, 3));
         duty_wr_data = W'($urandom_range(0, 20));
         update_req   = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 15) == 0)
            period = W'($urandom_range(0, 12));
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
